// File: rtl/btn_filter_pkg.sv
// Shared button indices, direction codes and the priority encoder helper for the move path.
// Pure definitions, no state.
package btn_filter_pkg;

    localparam int BTN_NUM   = 4;
    localparam int BTN_IDX_U = 0;
    localparam int BTN_IDX_D = 1;
    localparam int BTN_IDX_L = 2;
    localparam int BTN_IDX_R = 3;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    // Priority u > d > l > r; caller decides what to do when nothing is held.
    function automatic dir_e dir_encode(input logic [BTN_NUM-1:0] lvl);
        dir_e d;
        d = DIR_RIGHT;
        if (lvl[BTN_IDX_U])      d = DIR_UP;
        else if (lvl[BTN_IDX_D]) d = DIR_DOWN;
        else if (lvl[BTN_IDX_L]) d = DIR_LEFT;
        return d;
    endfunction

endpackage

// File: rtl/btn_filter_ch.sv
// One button channel: 2-FF synchroniser, debounce counter, stable level and press pulse.
// Level follows pin after 2 + DEBOUNCE_CYCLES clocks, press one clock later; no backpressure.
module btn_filter_ch #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_press
);
    import btn_filter_pkg::*;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_meta;
    logic                 r_sync;
    logic                 r_st;
    logic                 r_st_d;
    logic                 r_press;
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_st    <= 1'b0;
            r_st_d  <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_meta  <= i_pin;
            r_sync  <= r_meta;
            r_st_d  <= r_st;
            r_press <= r_st & ~r_st_d;
            // Any sample matching the stable level restarts the run, so glitches never accumulate.
            if (r_sync == r_st) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_MAX) begin
                r_st  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_lvl   = r_st;
    assign o_press = r_press;

endmodule

// File: rtl/btn_filter.sv
// Four debounced push-buttons plus registered move_en/direction encoder for the player plane.
// Encoder outputs lag btn_lvl_o by one clock; no backpressure.
module btn_filter
    import btn_filter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_u_pin_i,
    input  logic               btn_d_pin_i,
    input  logic               btn_l_pin_i,
    input  logic               btn_r_pin_i,
    output logic [BTN_NUM-1:0] btn_lvl_o,
    output logic [BTN_NUM-1:0] btn_press_o,
    output logic               move_en_o,
    output logic [1:0]         direct_o
);

    logic [BTN_NUM-1:0] w_pins;
    logic [BTN_NUM-1:0] w_lvl;
    logic [BTN_NUM-1:0] w_press;
    logic               r_move_en;
    dir_e               r_direct;

    always_comb begin
        w_pins            = '0;
        w_pins[BTN_IDX_U] = btn_u_pin_i;
        w_pins[BTN_IDX_D] = btn_d_pin_i;
        w_pins[BTN_IDX_L] = btn_l_pin_i;
        w_pins[BTN_IDX_R] = btn_r_pin_i;
    end

    for (genvar g = 0; g < BTN_NUM; g++) begin : g_ch
        btn_filter_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_WIDTH       (CNT_WIDTH)
        ) u_ch (
            .i_clk   (clk),
            .i_rst_n (rst),
            .i_pin   (w_pins[g]),
            .o_lvl   (w_lvl[g]),
            .o_press (w_press[g])
        );
    end

    // Direction is sticky across releases so the move path keeps its last heading.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_move_en <= 1'b0;
            r_direct  <= DIR_UP;
        end else begin
            r_move_en <= |w_lvl;
            if (|w_lvl) begin
                r_direct <= dir_encode(w_lvl);
            end
        end
    end

    assign btn_lvl_o   = w_lvl;
    assign btn_press_o = w_press;
    assign move_en_o   = r_move_en;
    assign direct_o    = r_direct;

endmodule

// File: tb/tb_btn_filter.sv
// Bench for btn_filter: cycle model feeding a scoreboard queue, plus directed timing checks.
module tb_btn_filter;

    localparam int DEB = 4;
    localparam int CW  = 3;

    logic       clk;
    logic       rst;
    logic       pin_u, pin_d, pin_l, pin_r;
    logic [3:0] lvl, press;
    logic       move_en;
    logic [1:0] direct;

    int checks   = 0;
    int failures = 0;

    btn_filter #(.DEBOUNCE_CYCLES(DEB), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_u_pin_i (pin_u),
        .btn_d_pin_i (pin_d),
        .btn_l_pin_i (pin_l),
        .btn_r_pin_i (pin_r),
        .btn_lvl_o   (lvl),
        .btn_press_o (press),
        .move_en_o   (move_en),
        .direct_o    (direct)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] press;
        logic       en;
        logic [1:0] dir;
    } exp_t;

    exp_t sb_q[$];

    logic [3:0] m_s1 = '0, m_s2 = '0, m_st = '0, m_std = '0, m_press = '0;
    int         m_cnt [4] = '{0, 0, 0, 0};
    logic       m_en  = 1'b0;
    logic [1:0] m_dir = 2'b00;

    always @(posedge clk or negedge rst) begin
        logic [3:0] pins, st_n;
        exp_t e;
        if (!rst) begin
            m_s1 = '0; m_s2 = '0; m_st = '0; m_std = '0; m_press = '0;
            m_en = 1'b0; m_dir = 2'b00;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            sb_q.delete();
        end else begin
            pins = {pin_r, pin_l, pin_d, pin_u};
            st_n = m_st;
            for (int i = 0; i < 4; i++) begin
                if (m_s2[i] == m_st[i]) m_cnt[i] = 0;
                else if (m_cnt[i] == DEB - 1) begin
                    st_n[i]  = m_s2[i];
                    m_cnt[i] = 0;
                end else m_cnt[i] = m_cnt[i] + 1;
            end
            m_press = m_st & ~m_std;
            m_std   = m_st;
            m_en    = |m_st;
            if (m_st[0])      m_dir = 2'b00;
            else if (m_st[1]) m_dir = 2'b01;
            else if (m_st[2]) m_dir = 2'b10;
            else if (m_st[3]) m_dir = 2'b11;
            m_s2 = m_s1;
            m_s1 = pins;
            m_st = st_n;
            e.lvl = m_st; e.press = m_press; e.en = m_en; e.dir = m_dir;
            sb_q.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("sb_lvl",   16'(lvl),     16'(e.lvl));
            check("sb_press", 16'(press),   16'(e.press));
            check("sb_en",    16'(move_en), 16'(e.en));
            check("sb_dir",   16'(direct),  16'(e.dir));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pins(input logic [3:0] p);
        {pin_r, pin_l, pin_d, pin_u} = p;
    endtask

    initial begin
        // 1: reset with all pins high, then acquisition
        rst = 1'b1;
        set_pins(4'hF);
        #2 rst = 1'b0;
        #1;
        check("rst_lvl",   16'(lvl),     16'h0);
        check("rst_press", 16'(press),   16'h0);
        check("rst_en",    16'(move_en), 16'h0);
        check("rst_dir",   16'(direct),  16'h0);
        tick(3);
        rst = 1'b1;
        tick(5);  check("t1_lvl_early", 16'(lvl), 16'h0);
        tick(1);  check("t1_lvl",       16'(lvl), 16'hF);
        tick(1);  check("t1_en",  16'(move_en), 16'h1);
                  check("t1_dir", 16'(direct),  16'h0);
                  check("t1_press", 16'(press), 16'hF);
        tick(1);  check("t1_press_end", 16'(press), 16'h0);

        // 2: clean press and release of up
        set_pins(4'h0);
        tick(10); check("t2_idle", 16'(lvl), 16'h0);
        set_pins(4'b0001);
        tick(5);  check("t2_lvl_early", 16'(lvl), 16'h0);
        tick(1);  check("t2_lvl", 16'(lvl), 16'h1);
                  check("t2_no_press_yet", 16'(press), 16'h0);
        tick(1);  check("t2_press", 16'(press), 16'b0001);
        tick(1);  check("t2_press_end", 16'(press), 16'h0);
        set_pins(4'h0);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            check("t2_rel_no_press", 16'(press), 16'h0);
            if (k == 5) check("t2_rel_lvl_held", 16'(lvl), 16'h1);
            if (k == 6) check("t2_rel_lvl", 16'(lvl), 16'h0);
        end
        check("t2_rel_en", 16'(move_en), 16'h0);

        // 3: short glitch on left, then bounce
        set_pins(4'b0100);
        tick(3);
        set_pins(4'h0);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("t3_glitch_lvl",   16'(lvl),   16'h0);
            check("t3_glitch_press", 16'(press), 16'h0);
        end
        set_pins(4'b0100); tick(1);
        set_pins(4'b0000); tick(1);
        set_pins(4'b0100);
        tick(5);  check("t3_bounce_early", 16'(lvl), 16'h0);
        tick(1);  check("t3_bounce_lvl",   16'(lvl), 16'b0100);
        tick(1);  check("t3_bounce_press", 16'(press), 16'b0100);
                  check("t3_dir_left",     16'(direct), 16'b10);
        set_pins(4'h0);
        tick(10); check("t3_dir_hold", 16'(direct),  16'b10);
                  check("t3_en_off",   16'(move_en), 16'h0);

        // 4: priority
        set_pins(4'b1000);
        tick(8);  check("t4_r",    16'(direct), 16'b11);
                  check("t4_r_en", 16'(move_en), 16'h1);
        set_pins(4'b1010);
        tick(8);  check("t4_rd", 16'(direct), 16'b01);
        set_pins(4'b1011);
        tick(8);  check("t4_rdu", 16'(direct), 16'b00);
                  check("t4_lvl", 16'(lvl),    16'b1011);
        set_pins(4'h0);
        tick(8);  check("t4_rel_en",  16'(move_en), 16'h0);
                  check("t4_rel_dir", 16'(direct),  16'b00);

        // 5: simultaneous up+down
        set_pins(4'b0011);
        tick(6);  check("t5_lvl", 16'(lvl), 16'b0011);
        tick(1);  check("t5_press", 16'(press), 16'b0011);
                  check("t5_dir",   16'(direct), 16'b00);
        tick(1);  check("t5_press_end", 16'(press), 16'h0);
        set_pins(4'h0);
        tick(10);

        // 6: async reset mid-count
        set_pins(4'b1000);
        tick(8);  check("t6_pre_dir", 16'(direct), 16'b11);
        set_pins(4'b1010);
        tick(4);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_lvl", 16'(lvl),     16'h0);
        check("t6_rst_en",  16'(move_en), 16'h0);
        check("t6_rst_dir", 16'(direct),  16'h0);
        @(negedge clk);
        rst = 1'b1;
        tick(5);  check("t6_lvl_early", 16'(lvl), 16'h0);
        tick(1);  check("t6_lvl", 16'(lvl), 16'b1010);
        tick(1);  check("t6_dir",   16'(direct),  16'b01);
                  check("t6_en",    16'(move_en), 16'h1);
                  check("t6_press", 16'(press),   16'b1010);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
